// File: rtl/arm_enc_pkg.sv
// Shared encoding constants for the ARM program-loader encoder: descriptor
// class codes, Op field values, the MUL marker and the loader FSM states.
package arm_enc_pkg;

    typedef enum logic [2:0] {
        CLS_DP_REG = 3'd0,
        CLS_DP_IMM = 3'd1,
        CLS_MEM    = 3'd2,
        CLS_BR     = 3'd3,
        CLS_MUL    = 3'd4
    } cls_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] MUL_FUNCT = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns one instruction descriptor into the
// 32-bit machine word the core's decode stage expects.
module instr_pack
    import arm_enc_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [3:0]  cond,
    input  logic [3:0]  cmd,
    input  logic        s,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rm,
    input  logic [3:0]  rs,
    input  logic [11:0] imm12,
    input  logic        ld,
    input  logic        up,
    input  logic        byt,
    input  logic        link,
    input  logic [23:0] imm24,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (cls_t'(cls))
            CLS_DP_REG: word = {cond, OP_DP, 1'b0, cmd, s, rn, rd, 8'h00, rm};
            CLS_DP_IMM: word = {cond, OP_DP, 1'b1, cmd, s, rn, rd, imm12};
            // Offset addressing only: P=1, W=0.
            CLS_MEM:    word = {cond, OP_MEM, 1'b0, 1'b1, up, byt, 1'b0, ld, rn, rd, imm12};
            CLS_BR:     word = {cond, OP_BR, 1'b1, link, imm24};
            CLS_MUL:    word = {cond, 6'b000000, 1'b0, s, rd, 4'b0000, rs, MUL_FUNCT, rm};
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts descriptors, encodes them and streams the words to
// consecutive instruction-memory addresses through a one-entry write register.
module instr_encoder
    import arm_enc_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        cls,
    input  logic [3:0]        cond,
    input  logic [3:0]        cmd,
    input  logic              s,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [3:0]        rm,
    input  logic [3:0]        rs,
    input  logic [11:0]       imm12,
    input  logic              ld,
    input  logic              up,
    input  logic              byt,
    input  logic              link,
    input  logic [23:0]       imm24,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic              wr_pend;
    logic [ADDR_W-1:0] addr_ptr;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic [31:0]       word;
    logic              legal;
    logic              hs, accept;
    logic [ADDR_W:0]   issued;

    instr_pack u_pack (
        .cls   (cls),
        .cond  (cond),
        .cmd   (cmd),
        .s     (s),
        .rn    (rn),
        .rd    (rd),
        .rm    (rm),
        .rs    (rs),
        .imm12 (imm12),
        .ld    (ld),
        .up    (up),
        .byt   (byt),
        .link  (link),
        .imm24 (imm24),
        .word  (word),
        .legal (legal)
    );

    assign hs     = wr_pend && mem_ready;
    // Words committed plus the one in flight; never let this pass capacity.
    assign issued = count_q + {{ADDR_W{1'b0}}, wr_pend};

    assign in_ready = (state_q == ST_LOAD) && !start && !(wr_pend && !mem_ready)
                      && (issued < CAP);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_LOAD;
        end else if (state_q == ST_LOAD && hs && (count_q + 1'b1) == CAP) begin
            state_d = ST_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pend  <= 1'b0;
            addr_ptr <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
        end else if (start) begin
            wr_pend  <= 1'b0;
            addr_ptr <= BASE;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (hs) begin
                count_q  <= count_q + 1'b1;
                addr_ptr <= addr_ptr + 1'b1;
            end
            if (accept && legal) begin
                wr_pend  <= 1'b1;
                mem_wd   <= word;
                // A completing write frees addr_ptr this cycle; take the next one.
                mem_addr <= hs ? addr_ptr + 1'b1 : addr_ptr;
            end else if (hs) begin
                wr_pend <= 1'b0;
            end
            if (accept && !legal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_we = wr_pend;
    assign count  = count_q;
    assign full   = (state_q == ST_FULL);
    assign err    = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=2): directed descriptors, a
// per-cycle reference model of the loader, and literal word checks.
module tb_instr_encoder;

    localparam int AW   = 2;
    localparam int CAP  = 4;
    localparam int BASE = 0;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    cls;
    logic [3:0]    cond, cmd, rn, rd, rm, rs;
    logic          s;
    logic [11:0]   imm12;
    logic          ld, up, byt, link;
    logic [23:0]   imm24;
    logic          mem_we;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];
    int          exp_addr_q[$];
    int          model_count = 0;
    int          issued      = 0;
    logic        err_m       = 1'b0;
    logic        open        = 1'b0;

    logic [31:0] log_wd[$];
    int          log_addr[$];
    int          log_cyc[$];

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cls       (cls),
        .cond      (cond),
        .cmd       (cmd),
        .s         (s),
        .rn        (rn),
        .rd        (rd),
        .rm        (rm),
        .rs        (rs),
        .imm12     (imm12),
        .ld        (ld),
        .up        (up),
        .byt       (byt),
        .link      (link),
        .imm24     (imm24),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within 20000 cycles");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference encoder built by placing each field at its bit position.
    function automatic logic [31:0] model_word(
        input logic [2:0] c, input logic [3:0] cd, input logic [3:0] cm,
        input logic sb, input logic [3:0] n, input logic [3:0] d,
        input logic [3:0] m, input logic [3:0] t, input logic [11:0] i12,
        input logic l, input logic u, input logic b, input logic lk,
        input logic [23:0] i24);
        logic [31:0] w;
        w = 32'(cd) << 28;
        case (c)
            3'd0: w = w | (32'(cm) << 21) | (32'(sb) << 20) | (32'(n) << 16)
                        | (32'(d) << 12) | 32'(m);
            3'd1: w = w | (32'd1 << 25) | (32'(cm) << 21) | (32'(sb) << 20)
                        | (32'(n) << 16) | (32'(d) << 12) | 32'(i12);
            3'd2: w = w | (32'd1 << 26) | (32'd1 << 24) | (32'(u) << 23)
                        | (32'(b) << 22) | (32'(l) << 20) | (32'(n) << 16)
                        | (32'(d) << 12) | 32'(i12);
            3'd3: w = w | (32'd5 << 25) | (32'(lk) << 24) | 32'(i24);
            3'd4: w = w | (32'(sb) << 20) | (32'(d) << 16) | (32'(t) << 8)
                        | (32'd9 << 4) | 32'(m);
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // ---------------- model + compare (every cycle) ----------------
    always @(negedge clk) begin
        logic exp_ready;
        if (reset) begin
            exp_q.delete();
            exp_addr_q.delete();
            model_count = 0;
            issued      = 0;
            err_m       = 1'b0;
            open        = 1'b0;
        end else begin
            exp_ready = open && !start && (exp_q.size() == 0 || mem_ready)
                        && (model_count + exp_q.size() < CAP);
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("mem_we", 32'(mem_we), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("mem_wd", mem_wd, exp_q[0]);
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q[0]));
            end
            chk("count", 32'(count), 32'(model_count));
            chk("full", 32'(full), 32'(model_count == CAP));
            chk("err", 32'(err), 32'(err_m));

            if (mem_we && mem_ready) begin
                log_wd.push_back(mem_wd);
                log_addr.push_back(int'(mem_addr));
                log_cyc.push_back(cyc);
            end
            if (exp_q.size() != 0 && mem_ready) begin
                void'(exp_q.pop_front());
                void'(exp_addr_q.pop_front());
                model_count++;
            end
            if (in_valid && exp_ready) begin
                if (cls <= 3'd4) begin
                    exp_q.push_back(model_word(cls, cond, cmd, s, rn, rd, rm, rs,
                                               imm12, ld, up, byt, link, imm24));
                    exp_addr_q.push_back((BASE + issued) % CAP);
                    issued++;
                end else begin
                    err_m = 1'b1;
                end
            end
            if (start) begin
                exp_q.delete();
                exp_addr_q.delete();
                model_count = 0;
                issued      = 0;
                err_m       = 1'b0;
                open        = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_desc(
        input logic [2:0] c, input logic [3:0] cd, input logic [3:0] cm,
        input logic sb, input logic [3:0] n, input logic [3:0] d,
        input logic [3:0] m, input logic [3:0] t, input logic [11:0] i12,
        input logic l, input logic u, input logic b, input logic lk,
        input logic [23:0] i24);
        cls = c; cond = cd; cmd = cm; s = sb; rn = n; rd = d; rm = m; rs = t;
        imm12 = i12; ld = l; up = u; byt = b; link = lk; imm24 = i24;
    endtask

    task automatic send();
        int  n;
        logic got;
        n   = 0;
        got = 1'b0;
        in_valid = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            step();
            n++;
        end
        in_valid = 1'b0;
        chk("send_accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (mem_we && n < 50) begin
            step();
            n++;
        end
        chk("drain", 32'(mem_we), 32'd0);
    endtask

    task automatic rand_desc();
        set_desc(3'($urandom_range(0, 4)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 24'($urandom_range(0, 16777215)));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        set_desc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Pin the reference encoder to hand-assembled words.
        chk("model_add", model_word(0, 4'hE, 4, 0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0), 32'hE0821003);
        chk("model_mul", model_word(4, 4'hE, 0, 1, 0, 4, 5, 6, 0, 0, 0, 0, 0, 0), 32'hE0140695);
        chk("model_ldr", model_word(2, 4'hE, 0, 0, 1, 0, 0, 0, 12'h008, 1, 1, 0, 0, 0), 32'hE5910008);
        chk("model_b",   model_word(3, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 24'hFFFFFE), 32'hEAFFFFFE);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // ADD r1,r2,r3
        pulse_start();
        set_desc(0, 4'hE, 4, 0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        send();
        chk("add_we", 32'(mem_we), 32'd1);
        chk("add_wd", mem_wd, 32'hE0821003);
        chk("add_addr", 32'(mem_addr), 32'd0);
        step();
        chk("add_count", 32'(count), 32'd1);

        // MULS r4,r5,r6
        pulse_start();
        set_desc(4, 4'hE, 0, 1, 0, 4, 5, 6, 0, 0, 0, 0, 0, 0);
        send();
        chk("mul_wd", mem_wd, 32'hE0140695);
        chk("mul_funct", 32'(mem_wd[7:4]), 32'h9);
        wait_drain();

        // LDR r0,[r1,#8] then B .-? (imm24=0xFFFFFE), back to back
        pulse_start();
        base = log_wd.size();
        set_desc(2, 4'hE, 0, 0, 1, 0, 0, 0, 12'h008, 1, 1, 0, 0, 0);
        send();
        set_desc(3, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 24'hFFFFFE);
        send();
        wait_drain();
        chk("ldr_b_nwrites", 32'(log_wd.size()), 32'(base + 2));
        if (log_wd.size() >= base + 2) begin
            chk("ldr_wd", log_wd[base], 32'hE5910008);
            chk("ldr_addr", 32'(log_addr[base]), 32'd0);
            chk("b_wd", log_wd[base+1], 32'hEAFFFFFE);
            chk("b_addr", 32'(log_addr[base+1]), 32'd1);
        end

        // Backpressure: hold mem_ready low with a second descriptor waiting
        pulse_start();
        mem_ready = 1'b0;
        set_desc(1, 4'hE, 4, 0, 1, 2, 0, 0, 12'h0FF, 0, 0, 0, 0, 0);
        send();
        set_desc(0, 4'h1, 2, 1, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_wd", mem_wd, 32'hE28120FF);
            step();
        end
        base = log_wd.size();
        mem_ready = 1'b1;
        send();
        wait_drain();
        chk("hold_nwrites", 32'(log_wd.size()), 32'(base + 2));
        if (log_wd.size() >= base + 2) begin
            chk("hold_back_to_back", 32'(log_cyc[base+1] - log_cyc[base]), 32'd1);
            chk("hold_addr1", 32'(log_addr[base+1]), 32'd1);
            chk("hold_wd1", log_wd[base+1], 32'h10534005);
        end

        // Capacity: 4 words fill ADDR_W=2, a 5th is refused
        pulse_start();
        for (int i = 0; i < CAP; i++) begin
            rand_desc();
            send();
        end
        rand_desc();
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        pulse_start();
        chk("restart_count", 32'(count), 32'd0);
        chk("restart_full", 32'(full), 32'd0);
        base = log_wd.size();
        set_desc(3, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 24'h000010);
        send();
        wait_drain();
        chk("restart_nwrites", 32'(log_wd.size()), 32'(base + 1));
        if (log_wd.size() >= base + 1) begin
            chk("restart_addr", 32'(log_addr[base]), 32'(BASE));
            chk("restart_wd", log_wd[base], 32'h0B000010);
        end

        // Illegal class sets err and consumes no address
        pulse_start();
        set_desc(6, 4'hE, 4, 0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        send();
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_no_write", 32'(mem_we), 32'd0);
        base = log_wd.size();
        set_desc(0, 4'hE, 4, 0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        send();
        wait_drain();
        chk("illegal_nwrites", 32'(log_wd.size()), 32'(base + 1));
        if (log_wd.size() >= base + 1) begin
            chk("after_illegal_addr", 32'(log_addr[base]), 32'd0);
        end
        chk("err_sticky", 32'(err), 32'd1);
        pulse_start();
        chk("start_clears_err", 32'(err), 32'd0);

        // start beats in_valid in the same cycle
        set_desc(0, 4'hE, 4, 0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        chk("start_prio_ready", 32'(in_ready), 32'd0);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_prio_we", 32'(mem_we), 32'd0);

        // start discards a write stalled by mem_ready=0
        mem_ready = 1'b0;
        send();
        chk("stall_we", 32'(mem_we), 32'd1);
        pulse_start();
        chk("start_drops_we", 32'(mem_we), 32'd0);
        chk("start_drops_count", 32'(count), 32'd0);
        mem_ready = 1'b1;

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
